// File: rtl/alu_uart_interface_pkg.sv
// Shared definitions for the UART-to-ALU sequencing stage: FSM encodings
// and the ALU opcode set understood by the attached combinational ALU.
package alu_uart_interface_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_OP1    = 3'd0,
    ST_WAIT_OP2    = 3'd1,
    ST_WAIT_OPCODE = 3'd2,
    ST_SEND        = 3'd3,
    ST_WAIT_TX     = 3'd4
  } state_t;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;

  // States in which the block owns the transmitter and ignores received bytes.
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/alu_uart_interface_timeout.sv
// Inter-byte timer: counts enabled cycles, flags the last allowed cycle and
// saturates there so it can never wrap back into a false "fresh" count.
module timeout_counter #(
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_done
);

  localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count_q;
  logic [NB_TIMEOUT-1:0] count_d;

  // Next count: clear wins, otherwise advance while enabled up to the limit.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != LAST_COUNT)) begin
      count_d = count_q + NB_TIMEOUT'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_done = i_enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// presents them as registered ALU inputs, then sends the ALU result back
// through the UART transmitter with a one-cycle start pulse.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OPCODE      = 6,
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic [NB_DATA-1:0]   o_first_operator,
  output logic [NB_DATA-1:0]   o_second_operator,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy
);

  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   first_q, first_d;
  logic [NB_DATA-1:0]   second_q, second_d;
  logic [NB_OPCODE-1:0] opcode_q, opcode_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;

  logic tmo_enable;
  logic tmo_clear;
  logic tmo_done;

  // The timer only guards the gaps inside a frame; any byte or state move restarts it.
  assign tmo_enable = (state_q == ST_WAIT_OP2) || (state_q == ST_WAIT_OPCODE);
  assign tmo_clear  = i_rx_done || (state_d != state_q);

  timeout_counter #(
    .NB_TIMEOUT     (NB_TIMEOUT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (tmo_enable),
    .i_clear  (tmo_clear),
    .o_done   (tmo_done)
  );

  // Next-state and capture logic; a received byte always beats a timeout.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    second_d   = second_q;
    opcode_d   = opcode_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    case (state_q)
      ST_WAIT_OP1: begin
        if (i_rx_done) begin
          first_d = i_rx_data;
          state_d = ST_WAIT_OP2;
        end
      end
      ST_WAIT_OP2: begin
        if (i_rx_done) begin
          second_d = i_rx_data;
          state_d  = ST_WAIT_OPCODE;
        end else if (tmo_done) begin
          state_d = ST_WAIT_OP1;
        end
      end
      ST_WAIT_OPCODE: begin
        if (i_rx_done) begin
          opcode_d = i_rx_data[NB_OPCODE-1:0];
          state_d  = ST_SEND;
        end else if (tmo_done) begin
          state_d = ST_WAIT_OP1;
        end
      end
      ST_SEND: begin
        // One settle cycle so the ALU sees the freshly registered opcode.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // Bytes arriving here are dropped; only the transmitter ends the frame.
        if (i_tx_done) begin
          state_d = ST_WAIT_OP1;
        end
      end
      default: begin
        state_d = ST_WAIT_OP1;
      end
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_WAIT_OP1;
      first_q    <= '0;
      second_q   <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      second_q   <= second_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign o_first_operator  = first_q;
  assign o_second_operator = second_q;
  assign o_opcode          = opcode_q;
  assign o_tx_data         = tx_data_q;
  assign o_tx_start        = tx_start_q;
  assign o_busy            = is_busy_state(state_q);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed frames from the test plan followed
// by randomized frames, gaps, dropped bytes and resets, all checked against
// a frame-level reference model.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_res;
  logic [7:0] first, second, tx_data;
  logic [5:0] opcode;
  logic       tx_start, busy;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: position in frame (0..2 waiting for byte, 3 = busy).
  int         m_pos;
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  int         gap_cnt;
  int         exp_starts;
  int         starts_seen = 0;

  logic [5:0] op_list [9] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                              OP_SRA, OP_SRL, OP_NOR, 6'h3F};

  always #5 clk = ~clk;

  alu_uart_interface #(
    .NB_DATA(8), .NB_OPCODE(6), .NB_TIMEOUT(20), .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_result(alu_res),
    .o_first_operator(first), .o_second_operator(second), .o_opcode(opcode),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy)
  );

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SRA:  return 8'($signed(a) >>> b);
      OP_SRL:  return a >> b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  // Combinational ALU in front of the DUT.
  always_comb alu_res = alu_ref(first, second, opcode);

  // Count every start pulse the DUT emits.
  always @(negedge clk) if (tx_start) starts_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_a"}, first, m_a);
    chk({tag, "_b"}, second, m_b);
    chk({tag, "_op"}, opcode, m_op);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pos = 0; m_a = 0; m_b = 0; m_op = 0; m_tx = 0; gap_cnt = 0;
    check_regs("rst");
    chk("rst_txdata", tx_data, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    $display("reset");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    gap_cnt += n;
  endtask

  // Send one byte; when raw=0 and it lands in the opcode slot, pick a listed opcode.
  task automatic put_byte(input logic [7:0] b_in, input bit raw);
    logic [7:0] b;
    b = b_in;
    if ((m_pos == 1 || m_pos == 2) && gap_cnt >= T) m_pos = 0;
    if (!raw && m_pos == 2) b[5:0] = op_list[$urandom_range(0, 8)];
    rx_data = b; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    case (m_pos)
      0: begin m_a = b; m_pos = 1; end
      1: begin m_b = b; m_pos = 2; end
      2: begin m_op = b[5:0]; m_pos = 3; m_tx = alu_ref(m_a, m_b, m_op); end
      default: ;
    endcase
    gap_cnt = 0;
    $display("rx byte %02h -> pos %0d", b, m_pos);
    check_regs("byte");
  endtask

  // Called right after the opcode byte: SEND now, start pulse next cycle only.
  task automatic check_tx();
    chk("send_busy", busy, 1);
    chk("send_nostart", tx_start, 0);
    @(negedge clk);
    exp_starts++;
    chk("tx_start", tx_start, 1);
    chk("tx_data", tx_data, m_tx);
    chk("wait_busy", busy, 1);
    @(negedge clk);
    chk("start_once", tx_start, 0);
    $display("tx start data=%02h expected=%02h", tx_data, m_tx);
  endtask

  task automatic finish_tx(input int n_idle, input bit inject, input bit together);
    repeat (n_idle) @(negedge clk);
    if (inject) begin
      rx_data = 8'h7F; rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      check_regs("drop");
      chk("drop_busy", busy, 1);
    end
    tx_done = 1'b1;
    if (together) begin rx_data = 8'h7F; rx_done = 1'b1; end
    @(negedge clk);
    tx_done = 1'b0; rx_done = 1'b0;
    m_pos = 0; gap_cnt = 0;
    chk("done_busy", busy, 0);
    chk("done_hold", tx_data, m_tx);
    check_regs("done");
    $display("tx done inject=%0d together=%0d", inject, together);
  endtask

  initial begin
    rst = 1'b1; rx_data = 0; rx_done = 0; tx_done = 0;
    m_pos = 0; gap_cnt = 0; exp_starts = 0;
    m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
    repeat (2) @(negedge clk);
    do_reset();

    // ADD 05 + 03
    put_byte(8'h05, 1); idle(2); put_byte(8'h03, 1); idle(3); put_byte(8'h20, 1);
    check_tx(); chk("add_const", tx_data, 8'h08);
    finish_tx(3, 0, 0);

    // SUB with upper opcode bits set
    put_byte(8'h03, 1); put_byte(8'h05, 1); put_byte(8'hE2, 1);
    chk("sub_opcode", opcode, 6'b100010);
    check_tx(); chk("sub_const", tx_data, 8'hFE);
    finish_tx(1, 0, 0);

    // Timeout abort after first operand
    put_byte(8'h11, 1); idle(20); put_byte(8'h22, 1);
    chk("tmo_first", first, 8'h22);
    put_byte(8'h33, 1); put_byte(8'h24, 1);
    check_tx(); chk("and_const", tx_data, 8'h22);
    finish_tx(0, 1, 0);

    // Longest gap that still continues the frame
    put_byte(8'h40, 1); idle(T - 1); put_byte(8'h02, 1); idle(T - 1); put_byte(8'h20, 1);
    check_tx(); chk("edge_gap", tx_data, 8'h42);
    finish_tx(2, 1, 1);

    // Dropped byte then next frame
    put_byte(8'h01, 1); put_byte(8'h01, 1); put_byte(8'h20, 1);
    check_tx(); chk("after_drop", tx_data, 8'h02);
    finish_tx(0, 0, 0);

    // Reset after second operand
    put_byte(8'h09, 1); put_byte(8'h04, 1); do_reset();
    put_byte(8'hAA, 1); put_byte(8'h55, 1); put_byte(8'h3F, 1);
    check_tx(); chk("undef_const", tx_data, 8'h00);
    finish_tx(1, 0, 0);

    // Randomized frames
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 12 && m_pos != 3; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) idle($urandom_range(0, 3));
        else if (r == 7) idle(T - 1);
        else if (r == 8) idle(T);
        else idle(T + 2);
        if ($urandom_range(0, 19) == 0) do_reset();
        put_byte(8'($urandom), 0);
      end
      if (m_pos == 3) begin
        if ($urandom_range(0, 9) == 0) begin
          do_reset();
        end else begin
          check_tx();
          if ($urandom_range(0, 9) == 0) do_reset();
          else finish_tx($urandom_range(0, 4), 1'($urandom), 1'($urandom));
        end
      end
    end

    @(negedge clk);
    chk("start_count", starts_seen, exp_starts);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
